// File: rtl/mem_writeback.sv
// Memory/writeback stage: issues aligned data-cache requests for loads and stores,
// stalls upstream while a request is outstanding, and drives the regfile write port.
module mem_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_rs2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_rd,
  output logic [31:0] dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        load_regfile,
  output logic [4:0]  rd,
  output logic [31:0] regfile_in,
  output logic        misaligned
);

  // Handshake: a request (dmem_read/dmem_write) is a level held with stable
  // addr/wmask/wdata until the single-cycle dmem_resp; the cycle carrying
  // dmem_resp completes it. Upstream holds its slot while stall is high.
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state, state_next;
  logic        accept, is_mem, aligned, start_access, take_resp;
  logic [1:0]  off;
  logic [3:0]  wmask_next;
  logic [31:0] wdata_next;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        regwrite_q;
  logic        is_load_q;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    accept       = ex_valid && (state == IDLE);
    is_mem       = ex_load || ex_store;
    off          = ex_result[1:0];
    aligned      = 1'b0;
    wmask_next   = 4'b0000;
    wdata_next   = 32'h0;
    case (ex_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      default: aligned = (off == 2'b00);
    endcase
    start_access = accept && is_mem && aligned;
    take_resp    = (state == ACCESS) && dmem_resp;
    state_next   = state;
    if (start_access)   state_next = ACCESS;
    else if (take_resp) state_next = IDLE;
    if (ex_store && !ex_load) begin
      case (ex_funct3[1:0])
        2'b00: begin
          wmask_next = 4'b0001 << off;
          wdata_next = {4{ex_rs2[7:0]}};
        end
        2'b01: begin
          wmask_next = 4'b0011 << off;
          wdata_next = {2{ex_rs2[15:0]}};
        end
        default: begin
          wmask_next = 4'b1111;
          wdata_next = ex_rs2;
        end
      endcase
    end
  end

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    rdata_shifted = dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  assign stall = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_addr    <= 32'h0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_wmask   <= 4'b0000;
      dmem_wdata   <= 32'h0;
      load_regfile <= 1'b0;
      rd           <= 5'd0;
      regfile_in   <= 32'h0;
      misaligned   <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      regwrite_q   <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      load_regfile <= 1'b0;
      misaligned   <= 1'b0;
      if (take_resp) begin
        dmem_read  <= 1'b0;
        dmem_write <= 1'b0;
        if (is_load_q && regwrite_q && (rd_q != 5'd0)) begin
          load_regfile <= 1'b1;
          rd           <= rd_q;
          regfile_in   <= load_data;
        end
      end
      if (accept) begin
        if (!is_mem) begin
          if (ex_regwrite && (ex_rd != 5'd0)) begin
            load_regfile <= 1'b1;
            rd           <= ex_rd;
            regfile_in   <= ex_result;
          end
        end else if (!aligned) begin
          misaligned <= 1'b1;
        end else begin
          dmem_addr  <= {ex_result[31:2], 2'b00};
          dmem_read  <= ex_load;
          dmem_write <= ex_store && !ex_load;
          dmem_wmask <= wmask_next;
          dmem_wdata <= wdata_next;
          funct3_q   <= ex_funct3;
          off_q      <= off;
          rd_q       <= ex_rd;
          regwrite_q <= ex_regwrite;
          is_load_q  <= ex_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed scenarios plus random ops against a
// byte-lane reference model and a writeback scoreboard.
module tb_mem_writeback;

  logic        clk, rst;
  logic        ex_valid, ex_load, ex_store, ex_regwrite;
  logic [31:0] ex_result, ex_rs2;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [3:0]  dmem_wmask;
  logic        stall, load_regfile, misaligned;
  logic [4:0]  rd;
  logic [31:0] regfile_in;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];

  mem_writeback dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_load(ex_load), .ex_store(ex_store),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .dmem_addr(dmem_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall(stall), .load_regfile(load_regfile), .rd(rd), .regfile_in(regfile_in),
    .misaligned(misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_aligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] m;
    int o;
    m = 4'b0000;
    o = int'(addr % 4);
    for (int i = 0; i < 4; i++)
      if (i >= o && i < o + acc_size(f3)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w = w | (((rs2 >> (8 * (i % acc_size(f3)))) & 32'hFF) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (f3)
      3'b000:  return ((v & 32'hFF) >= 128) ? (v & 32'hFF) - 32'd256 : (v & 32'hFF);
      3'b001:  return ((v & 32'hFFFF) >= 32768) ? (v & 32'hFFFF) - 32'd65536 : (v & 32'hFFFF);
      3'b100:  return v & 32'hFF;
      3'b101:  return v & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_regwrite = 1'b0;
    ex_result = 32'h0; ex_rs2 = 32'h0; ex_funct3 = 3'b000; ex_rd = 5'd0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] r, input logic rw);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_regwrite = rw;
    ex_result = res; ex_rd = r; ex_funct3 = 3'($urandom_range(0, 7)); ex_rs2 = $urandom;
    if (rw && r != 5'd0) exp_q.push_back({r, res});
    step();
    check("alu_wb_en", 32'(load_regfile), 32'(rw && r != 5'd0));
    if (rw && r != 5'd0) begin
      check("alu_rd", 32'(rd), 32'(r));
      check("alu_data", regfile_in, res);
    end
    check("alu_stall", 32'(stall), 32'd0);
  endtask

  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] r, input int waits,
                        input logic [31:0] word);
    bit ok;
    ok = ref_aligned(f3, addr);
    ex_valid = 1'b1; ex_load = ld; ex_store = !ld; ex_regwrite = ld;
    ex_result = addr; ex_rs2 = rs2; ex_funct3 = f3; ex_rd = r;
    step();
    if (!ok) begin
      drive_idle();
      check("mis_pulse", 32'(misaligned), 32'd1);
      check("mis_rd", 32'(dmem_read), 32'd0);
      check("mis_wr", 32'(dmem_write), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_wb", 32'(load_regfile), 32'd0);
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      // junk on EX while busy must be ignored
      ex_valid = 1'b1; ex_load = 1'($urandom_range(0, 1)); ex_store = 1'b0;
      ex_regwrite = 1'b1; ex_rd = 5'($urandom_range(1, 31)); ex_result = $urandom;
      check("acc_stall", 32'(stall), 32'd1);
      check("acc_read", 32'(dmem_read), 32'(ld));
      check("acc_write", 32'(dmem_write), 32'(!ld));
      check("acc_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("acc_mis", 32'(misaligned), 32'd0);
      if (!ld) begin
        check("st_mask", 32'(dmem_wmask), 32'(ref_mask(f3, addr)));
        check("st_wdata", dmem_wdata, ref_wdata(f3, rs2));
      end
      if (k == waits) begin
        dmem_resp = 1'b1;
        dmem_rdata = word;
        if (ld && r != 5'd0) exp_q.push_back({r, ref_load(f3, addr, word)});
      end else begin
        dmem_rdata = $urandom;
      end
      step();
    end
    drive_idle();
    dmem_resp = 1'b0;
    dmem_rdata = $urandom;
    check("done_stall", 32'(stall), 32'd0);
    check("done_read", 32'(dmem_read), 32'd0);
    check("done_write", 32'(dmem_write), 32'd0);
    check("done_wb_en", 32'(load_regfile), 32'(ld && r != 5'd0));
    if (ld && r != 5'd0) begin
      check("ld_rd", 32'(rd), 32'(r));
      check("ld_data", regfile_in, ref_load(f3, addr, word));
    end
  endtask

  // scoreboard on every writeback pulse
  always @(negedge clk) begin
    if (load_regfile) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_wb", 32'd1, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("sb_rd", 32'(rd), 32'(e[36:32]));
        check("sb_data", regfile_in, e[31:0]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, dmem_addr, 32'h0);
    check({tag, "_rw"}, {30'h0, dmem_read, dmem_write}, 32'h0);
    check({tag, "_wmask"}, 32'(dmem_wmask), 32'h0);
    check({tag, "_wdata"}, dmem_wdata, 32'h0);
    check({tag, "_flags"}, {29'h0, stall, load_regfile, misaligned}, 32'h0);
    check({tag, "_rd"}, 32'(rd), 32'h0);
    check({tag, "_rfin"}, regfile_in, 32'h0);
  endtask

  initial begin
    logic [2:0] ld_codes[5];
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    drive_idle();
    dmem_resp = 1'b0;
    dmem_rdata = 32'h0;
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // ALU stream x5, x0, x7
    alu_op(32'd1, 5'd5, 1'b1);
    alu_op(32'd2, 5'd0, 1'b1);
    alu_op(32'd3, 5'd7, 1'b1);
    drive_idle();
    step();
    check("alu_tail_wb", 32'(load_regfile), 32'd0);

    // LB / LBU at 0x103
    mem_op(1'b1, 3'b000, 32'h103, 32'h0, 5'd9, 3, 32'h80FF_0000);
    check("lb_lit", regfile_in, 32'hFFFF_FF80);
    mem_op(1'b1, 3'b100, 32'h103, 32'h0, 5'd9, 3, 32'h80FF_0000);
    check("lbu_lit", regfile_in, 32'h0000_0080);

    // SH at 0x202
    mem_op(1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 1, 32'h0);
    check("sh_mask_lit", 32'(dmem_wmask), 32'hC);
    check("sh_wdata_lit", dmem_wdata, 32'hABCD_ABCD);

    // misaligned LW, next op accepted right after
    mem_op(1'b1, 3'b010, 32'h101, 32'h0, 5'd4, 0, 32'h0);
    alu_op(32'hDEAD_0001, 5'd4, 1'b1);
    drive_idle();

    // same-cycle response
    mem_op(1'b1, 3'b101, 32'h000, 32'h0, 5'd3, 0, 32'h0000_F00D);
    check("lhu_lit", regfile_in, 32'h0000_F00D);

    // reset in the middle of an access, late response ignored
    ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010; ex_result = 32'h40;
    ex_regwrite = 1'b1; ex_rd = 5'd8;
    step();
    drive_idle();
    check("rst_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    step();
    check_all_zero("rst_mid1");
    step();
    check_all_zero("rst_mid2");
    rst = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    dmem_resp = 1'b0;
    check("late_resp_wb", 32'(load_regfile), 32'd0);
    check("late_resp_stall", 32'(stall), 32'd0);
    step();
    check("late_resp_wb2", 32'(load_regfile), 32'd0);

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)
        alu_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else if (kind == 1)
        mem_op(1'b1, ld_codes[$urandom_range(0, 4)], $urandom, 32'h0,
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom);
      else
        mem_op(1'b0, 3'($urandom_range(0, 2)), $urandom, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 3), 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        drive_idle();
        step();
        check("gap_wb", 32'(load_regfile), 32'd0);
      end
    end
    drive_idle();
    step();
    step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
